// File: rtl/ibus_responder.sv
// Instruction-bus responder: accepts one fetch request and returns up to two consecutive
// instruction words read through a single-outstanding memory port (kseg0/kseg1 mapped).
module ibus_responder #(
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data_1,
  output logic [31:0] iresp_data_2,
  output logic        iresp_valid_2,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OffW = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] word1_q, word1_d;
  logic [31:0] word2_q, word2_d;
  logic        two2_q, two2_d;
  logic        valid2_q, valid2_d;
  logic        idle_req, misaligned;

  assign idle_req   = (state_q == StIdle) && ireq_valid;
  assign misaligned = idle_req && (ireq_addr[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    word1_d  = word1_q;
    word2_d  = word2_q;
    two2_d   = two2_q;
    valid2_d = valid2_q;
    case (state_q)
      StIdle: begin
        if (ireq_valid) begin
          valid2_d = 1'b0;
          if (ireq_addr[1:0] != 2'b00) begin
            // Misaligned fetch: answered immediately with zero data, no memory access.
            word1_d = '0;
            word2_d = '0;
          end else begin
            paddr_d = {3'b000, ireq_addr[28:0]};
            two2_d  = (ireq_addr[OffW-1:2] != '1);
            state_d = StReq1;
          end
        end
      end
      StReq1: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            word1_d = mem_rdata;
            state_d = two2_q ? StReq2 : StResp;
          end else begin
            state_d = StWait1;
          end
        end
      end
      StWait1: begin
        if (mem_data_ok) begin
          word1_d = mem_rdata;
          state_d = two2_q ? StReq2 : StResp;
        end
      end
      StReq2: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            word2_d = mem_rdata;
            state_d = StResp;
          end else begin
            state_d = StWait2;
          end
        end
      end
      StWait2: begin
        if (mem_data_ok) begin
          word2_d = mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        valid2_d = two2_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      word1_q  <= '0;
      word2_q  <= '0;
      two2_q   <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      word1_q  <= word1_d;
      word2_q  <= word2_d;
      two2_q   <= two2_d;
      valid2_q <= valid2_d;
    end
  end

  always_comb begin
    iresp_addr_ok = idle_req;
    iresp_data_ok = misaligned || (state_q == StResp);
    iresp_data_1  = misaligned ? 32'h0 : word1_q;
    iresp_data_2  = misaligned ? 32'h0 : word2_q;
    iresp_valid_2 = (state_q == StResp) ? two2_q : (misaligned ? 1'b0 : valid2_q);
    mem_req       = (state_q == StReq1) || (state_q == StReq2);
    mem_addr      = '0;
    if (state_q == StReq1) begin
      mem_addr = paddr_q;
    end else if (state_q == StReq2) begin
      mem_addr = paddr_q + 32'd4;
    end
  end

endmodule
